// File: rtl/wdb_data_dispatch_if.sv
// Write-dispatch port bundle: per-hash payload intake and per-channel issue/credit lines.
// Payload type is a parameter so this file carries no package dependency.
interface wdb_data_dispatch_if #(
    parameter type pld_t = logic [43:0]
);
    logic [3:0]       in_vld;
    logic [3:0]       in_rdy;
    pld_t [3:0]       in_pld;
    logic [7:0]       ch_vld;
    pld_t [7:0]       ch_pld;
    logic [7:0]       ch_credit_ret;
    logic [7:0]       credit_err;

    modport master (
        output in_vld, in_pld, ch_credit_ret,
        input  in_rdy, ch_vld, ch_pld, credit_err
    );

    modport slave (
        input  in_vld, in_pld, ch_credit_ret,
        output in_rdy, ch_vld, ch_pld, credit_err
    );
endinterface

// File: rtl/wdb_data_dispatch.sv
// Write-direction dispatcher: per hash group, a 2-entry FIFO feeding one of two
// credit-controlled channels with alternating preference. Groups are fully independent.
package vector_cache_pkg;
    typedef struct packed {
        logic [3:0] opcode;
        logic [7:0] addr;
    } cmd_pld_t;

    typedef struct packed {
        cmd_pld_t    cmd_pld;
        logic [31:0] data;
    } group_data_pld_t;
endpackage

module wdb_group
    import vector_cache_pkg::*;
#(
    parameter int CREDIT_NUM = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  group_data_pld_t       in_pld,
    input  logic [1:0]            ch_credit_ret,
    output logic [1:0]            ch_vld,
    output group_data_pld_t [1:0] ch_pld,
    output logic [1:0]            credit_err
);
    localparam int CW = $clog2(CREDIT_NUM + 1);
    localparam logic [CW-1:0] CRD_FULL = CW'(CREDIT_NUM);

    group_data_pld_t [1:0] mem;
    logic [1:0]            cnt;
    logic                  wr_ptr, rd_ptr;
    logic [1:0][CW-1:0]    crd;
    logic                  ptr;

    logic       head_vld, disp, sel, push;
    logic [1:0] crd_ok, dec;

    // in_rdy comes straight off the count flop; no path from in_vld or credit returns.
    assign in_rdy   = (cnt != 2'd2);
    assign head_vld = (cnt != 2'd0);
    assign push     = in_vld & in_rdy;

    always_comb begin
        crd_ok = {crd[1] != '0, crd[0] != '0};
        sel    = crd_ok[ptr] ? ptr : ~ptr;
        disp   = head_vld & (|crd_ok);
        dec    = 2'b00;
        if (disp) dec[sel] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            cnt    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_pld;
                wr_ptr      <= ~wr_ptr;
            end
            if (disp) rd_ptr <= ~rd_ptr;
            cnt <= cnt + 2'(push) - 2'(disp);
        end
    end

    // Same-cycle consume and return cancel, so a return alongside a dispatch is never an overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crd        <= {CRD_FULL, CRD_FULL};
            credit_err <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                case ({dec[c], ch_credit_ret[c]})
                    2'b10: crd[c] <= crd[c] - CW'(1);
                    2'b01: begin
                        if (crd[c] == CRD_FULL) credit_err[c] <= 1'b1;
                        else                    crd[c] <= crd[c] + CW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= 1'b0;
            ch_vld <= '0;
            ch_pld <= '0;
        end else begin
            ch_vld <= dec;
            if (disp) begin
                ch_pld[sel] <= mem[rd_ptr];
                ptr         <= ~sel;
            end
        end
    end
endmodule

module wdb_data_dispatch
    import vector_cache_pkg::*;
#(
    parameter int CREDIT_NUM = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wdb_data_dispatch_if.slave   bus
);
    localparam int CW = $clog2(CREDIT_NUM + 1);

    for (genvar g = 0; g < 4; g++) begin : g_grp
        wdb_group #(.CREDIT_NUM(CREDIT_NUM)) u_grp (
            .clk           (clk),
            .rst_n         (rst_n),
            .in_vld        (bus.in_vld[g]),
            .in_rdy        (bus.in_rdy[g]),
            .in_pld        (bus.in_pld[g]),
            .ch_credit_ret (bus.ch_credit_ret[2*g+1:2*g]),
            .ch_vld        (bus.ch_vld[2*g+1:2*g]),
            .ch_pld        (bus.ch_pld[2*g+1:2*g]),
            .credit_err    (bus.credit_err[2*g+1:2*g])
        );
    end

    if (CREDIT_NUM < 1 || CREDIT_NUM > 15 || CW < 1) begin : g_bad_param
        $error("CREDIT_NUM must be 1..15");
    end
endmodule

// File: tb/tb_wdb_data_dispatch.sv
// Randomized bench for wdb_data_dispatch against a queue/credit-count reference model.
module tb_wdb_data_dispatch;
    import vector_cache_pkg::*;
    localparam int CN = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wdb_data_dispatch_if #(.pld_t(group_data_pld_t)) bus ();

    wdb_data_dispatch #(.CREDIT_NUM(CN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [3:0]           drv_vld;
    group_data_pld_t      drv_pld [4];
    logic [7:0]           drv_ret;

    assign bus.in_vld        = drv_vld;
    assign bus.ch_credit_ret = drv_ret;
    for (genvar g = 0; g < 4; g++) begin : g_drv
        assign bus.in_pld[g] = drv_pld[g];
    end

    // reference model state
    group_data_pld_t q [4][$];
    int              crd [8];
    bit              ptr [4];
    logic [7:0]      e_vld, e_err;
    group_data_pld_t e_pld [8];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < 4; g++) begin
            q[g].delete();
            ptr[g] = 1'b0;
        end
        for (int c = 0; c < 8; c++) begin
            crd[c]   = CN;
            e_pld[c] = '0;
        end
        e_vld = '0;
        e_err = '0;
    endtask

    // One rising edge: decisions use state before the edge; returns count from the next cycle.
    task automatic model_edge();
        for (int g = 0; g < 4; g++) begin
            bit rdy = (q[g].size() < 2);
            int ch  = -1;
            if (q[g].size() > 0) begin
                int p = 2*g + int'(ptr[g]);
                int o = 2*g + 1 - int'(ptr[g]);
                if (crd[p] > 0)      ch = p;
                else if (crd[o] > 0) ch = o;
            end
            e_vld[2*g]   = 1'b0;
            e_vld[2*g+1] = 1'b0;
            if (ch >= 0) begin
                e_vld[ch] = 1'b1;
                e_pld[ch] = q[g].pop_front();
                crd[ch]   = crd[ch] - 1;
                ptr[g]    = (ch == 2*g);
            end
            if (drv_vld[g] && rdy) q[g].push_back(drv_pld[g]);
        end
        for (int c = 0; c < 8; c++) begin
            if (drv_ret[c]) begin
                if (crd[c] == CN) e_err[c] = 1'b1;
                else              crd[c]   = crd[c] + 1;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        logic [3:0] e_rdy;
        for (int g = 0; g < 4; g++) e_rdy[g] = (q[g].size() < 2);
        chk({tag, "_in_rdy"}, bus.in_rdy, e_rdy);
        chk({tag, "_ch_vld"}, bus.ch_vld, e_vld);
        chk({tag, "_credit_err"}, bus.credit_err, e_err);
        for (int c = 0; c < 8; c++) chk($sformatf("%s_ch_pld%0d", tag, c), bus.ch_pld[c], e_pld[c]);
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        compare_all(tag);
    endtask

    function automatic group_data_pld_t rand_pld();
        group_data_pld_t p;
        p.data           = $urandom;
        p.cmd_pld.opcode = 4'($urandom);
        p.cmd_pld.addr   = 8'($urandom);
        return p;
    endfunction

    task automatic rand_drive();
        for (int g = 0; g < 4; g++) begin
            drv_vld[g] = ($urandom_range(0, 3) != 0);
            drv_pld[g] = rand_pld();
        end
        for (int c = 0; c < 8; c++)
            drv_ret[c] = (crd[c] < CN) && ($urandom_range(0, 2) == 0);
    endtask

    initial begin
        group_data_pld_t t2;
        logic [1:0] seq [8];
        int n;

        drv_vld = '0;
        drv_ret = '0;
        for (int g = 0; g < 4; g++) drv_pld[g] = '0;
        model_reset();
        repeat (3) @(negedge clk);
        compare_all("rst");
        rst_n = 1'b1;

        repeat (10) cycle("idle");

        // single payload on hash 2
        t2 = rand_pld();
        t2.cmd_pld.opcode = 4'd0;
        drv_pld[2] = t2;
        drv_vld    = 4'b0100;
        cycle("t2a");
        drv_vld = '0;
        chk("t2_vld_c1", bus.ch_vld, 8'h00);
        cycle("t2b");
        chk("t2_vld_c2", bus.ch_vld, 8'h10);
        chk("t2_pld", bus.ch_pld[4], t2);
        drv_ret = 8'h10;
        cycle("t2r");
        drv_ret = '0;

        // hash 0 back-to-back, no returns
        n = 0;
        drv_vld = 4'b0001;
        for (int k = 0; k < 12; k++) begin
            drv_pld[0] = rand_pld();
            cycle("t3");
            if (bus.ch_vld[1:0] != 2'b00 && n < 8) begin
                seq[n] = bus.ch_vld[1:0];
                n++;
            end
        end
        drv_vld = '0;
        chk("t3_count", 64'(n), 64'd8);
        for (int k = 0; k < 8; k++) chk($sformatf("t3_seq%0d", k), seq[k], (k % 2 == 0) ? 2'b01 : 2'b10);
        chk("t3_rdy_low", bus.in_rdy[0], 1'b0);

        // all exhausted, return on channel 1
        drv_ret = 8'h02;
        cycle("t5a");
        drv_ret = '0;
        cycle("t5b");
        chk("t5_vld", bus.ch_vld, 8'h02);

        // overflow return on channel 5 is sticky
        drv_ret = 8'h20;
        cycle("t6a");
        drv_ret = '0;
        chk("t6_err", bus.credit_err[5], 1'b1);
        repeat (3) cycle("t6b");
        chk("t6_err_sticky", bus.credit_err[5], 1'b1);

        // refill hash 0 channels
        for (int k = 0; k < 2*CN; k++) begin
            drv_ret = {6'b0, crd[1] < CN, crd[0] < CN};
            cycle("refill");
        end

        for (int k = 0; k < 1500; k++) begin
            rand_drive();
            cycle("rnd");
        end

        // reset mid-stream
        rand_drive();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("midrst");
        @(posedge clk);
        @(negedge clk);
        compare_all("midrst_hold");
        drv_vld = '0;
        drv_ret = '0;
        rst_n   = 1'b1;

        for (int k = 0; k < 400; k++) begin
            rand_drive();
            cycle("rnd2");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
